// File: rtl/psi_seq_merge_if.sv
// Stream bundle for psi_seq_merge: the element input stream and the
// intersection output stream, both valid/ready handshaked.
interface psi_seq_merge_if #(
    parameter int W = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_last;

    // Producer of elements / consumer of the intersection
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // The merge engine
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/psi_seq_merge.sv
// psi_seq_merge: sequential private-set-intersection engine.
// Party 0 is loaded into a K-entry buffer; each following party is merged
// against it with a two-pointer walk that compacts matches in place
// (wr never overtakes rd). The surviving elements are streamed out.
// Optional feature: define PSI_ORDER_CHECK_EN to flag non-ascending input
// through the sticky order_err output; otherwise order_err is tied low.
module psi_seq_merge #(
    parameter int W = 32,
    parameter int K = 16,
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    psi_seq_merge_if.slave         s,
    output logic [$clog2(K+1)-1:0] out_count,
    output logic                   busy,
    output logic                   done,
    output logic                   order_err
);
    localparam int CW = $clog2(K + 1);
    localparam int AW = (K > 1) ? $clog2(K) : 1;
    localparam int PW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MERGE = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   p_q, p_d;
    logic [CW-1:0]   out_count_q, out_count_d;
    logic [W-1:0]    buf_q [K];

    logic            buf_we_s;
    logic [AW-1:0]   buf_widx_s;
    logic [W-1:0]    x_s;
    logic [W-1:0]    head_s;
    logic            have_s;
    logic [CW-1:0]   wr_n_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic [W-1:0]    out_data_s;
    logic            out_last_s;

    // Next-state and output decode for the load/merge/emit sequence
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        acc_d       = acc_q;
        p_d         = p_q;
        out_count_d = out_count_q;
        buf_we_s    = 1'b0;
        buf_widx_s  = wr_q[AW-1:0];
        x_s         = s.in_data;
        head_s      = buf_q[rd_q[AW-1:0]];
        have_s      = (rd_q < cnt_q);
        wr_n_s      = wr_q;
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        out_data_s  = {W{1'b0}};
        out_last_s  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    cnt_d       = '0;
                    rd_d        = '0;
                    wr_d        = '0;
                    acc_d       = '0;
                    p_d         = '0;
                    out_count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                in_ready_s = 1'b1;
                if (s.in_valid) begin
                    buf_we_s = 1'b1;
                    wr_d     = wr_q + CW'(1);
                    acc_d    = acc_q + CW'(1);
                    if (acc_q == CW'(K - 1)) begin
                        cnt_d   = CW'(K);
                        rd_d    = '0;
                        wr_d    = '0;
                        acc_d   = '0;
                        p_d     = PW'(1);
                        state_d = S_MERGE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_MERGE: begin
                if (have_s && (head_s < x_s)) begin
                    // Buffer head is behind the offered element: skip it
                    // without consuming the input.
                    in_ready_s = 1'b0;
                    if (s.in_valid) begin
                        rd_d = rd_q + CW'(1);
                    end else begin
                        rd_d = rd_q;
                    end
                end else begin
                    in_ready_s = 1'b1;
                    if (s.in_valid) begin
                        if (have_s && (head_s == x_s)) begin
                            buf_we_s = 1'b1;
                            wr_n_s   = wr_q + CW'(1);
                            rd_d     = rd_q + CW'(1);
                        end else begin
                            wr_n_s   = wr_q;
                        end
                        wr_d  = wr_n_s;
                        acc_d = acc_q + CW'(1);
                        if (acc_q == CW'(K - 1)) begin
                            cnt_d = wr_n_s;
                            rd_d  = '0;
                            wr_d  = '0;
                            acc_d = '0;
                            p_d   = p_q + PW'(1);
                            if (p_q == PW'(N - 1)) begin
                                state_d = (wr_n_s == '0) ? S_DONE : S_EMIT;
                            end else begin
                                state_d = S_MERGE;
                            end
                        end else begin
                            state_d = S_MERGE;
                        end
                    end else begin
                        state_d = S_MERGE;
                    end
                end
            end
            S_EMIT: begin
                if (have_s) begin
                    out_valid_s = 1'b1;
                    out_data_s  = head_s;
                    out_last_s  = (rd_q == (cnt_q - CW'(1)));
                    if (s.out_ready) begin
                        rd_d    = rd_q + CW'(1);
                        state_d = out_last_s ? S_DONE : S_EMIT;
                    end else begin
                        state_d = S_EMIT;
                    end
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Latch the result size as the done pulse begins
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            out_count_d = cnt_d;
        end else begin
            out_count_d = out_count_d;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            acc_q       <= acc_d;
            p_q         <= p_d;
            out_count_q <= out_count_d;
        end
    end

    // Intersection buffer; contents are meaningless outside a run
    always_ff @(posedge clk) begin
        if (buf_we_s) begin
            buf_q[buf_widx_s] <= x_s;
        end
    end

`ifdef PSI_ORDER_CHECK_EN
    logic         err_q, err_d;
    logic [W-1:0] prev_q, prev_d;
    logic         fire_s;

    // Sticky detection of a descending step within one party's elements
    always_comb begin
        err_d  = err_q;
        prev_d = prev_q;
        fire_s = in_ready_s & s.in_valid;
        if ((state_q == S_IDLE) && start) begin
            err_d = 1'b0;
        end else if (fire_s) begin
            if ((acc_q != '0) && (x_s < prev_q)) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end
            prev_d = x_s;
        end else begin
            err_d = err_q;
        end
    end

    // Ordering-check registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q  <= 1'b0;
            prev_q <= {W{1'b0}};
        end else begin
            err_q  <= err_d;
            prev_q <= prev_d;
        end
    end

    assign order_err = err_q;
`else
    assign order_err = 1'b0;
`endif

    assign s.in_ready  = in_ready_s;
    assign s.out_valid = out_valid_s;
    assign s.out_data  = out_data_s;
    assign s.out_last  = out_last_s;
    assign out_count   = out_count_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
endmodule

// File: doc/psi_seq_merge.md
# psi_seq_merge

Sequential private-set-intersection engine for the BMR/MPC circuit library: the next generation of the combinational bitonic PSI block. It accepts N parties' ascending K-element sets one element per cycle over a valid/ready stream. It keeps a running intersection in a K-entry buffer, refined party by party with a two-pointer merge, then streams out the final intersection. Gate count scales with K and W only. Any N ≥ 2 is supported, with no power-of-two restriction.

## Interface
- W, 32, element bit width (unsigned)
- K, 16, elements per party (≥1)
- N, 4, number of parties (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse, begins a run; ignored while busy
- in_valid  in  1  input element valid
- in_data  in  W  input element; parties supplied in order 0..N-1, K elements each, non-decreasing within a party
- in_ready  out  1  element accepted when in_valid & in_ready
- out_valid  out  1  output element valid
- out_ready  in  1  downstream ready
- out_data  out  W  intersection element, ascending
- out_last  out  1  marks final output element
- out_count  out  $clog2(K+1)  intersection size, valid from done
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- order_err  out  1  sticky ordering error (see Configuration)

## Operation
- States: IDLE → LOAD → MERGE → EMIT → DONE → IDLE.
- IDLE: in_ready=0. start moves to LOAD and clears cnt, party index p, rd, wr and order_err.
- LOAD: in_ready=1. Each accepted element is written to buf[wr] and wr increments. After K accepts: cnt←K, rd←0, wr←0, p←1, go to MERGE.
- MERGE, per accepted-or-stalled cycle with x=in_data:
  - rd<cnt and buf[rd]<x: in_ready=0, rd++ (skip). in_ready is combinational on in_data.
  - rd==cnt: accept and discard x.
  - buf[rd]==x: accept, buf[wr]←x, wr++, rd++.
  - buf[rd]>x: accept and discard.
- In-place compaction is safe because wr ≤ rd always.
- After K accepts in a party: cnt←wr, rd←0, wr←0, p++. Go to EMIT when p reaches N.
- cnt may reach 0. Remaining parties are still fully consumed; every element is accepted and discarded.
- Result is a multiset intersection: duplicates match pairwise.
- EMIT: out_valid=1 while rd<cnt, out_data=buf[rd]. rd advances on out_valid & out_ready. out_last=1 when rd==cnt-1. If cnt==0, go straight to DONE.
- DONE: done=1 for one cycle, out_count=cnt (held until next start), then IDLE.
- Comparisons are unsigned, full W bits.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, out_last=0, out_count=0, busy=0, done=0, order_err=0. FSM in IDLE, cnt/p/rd/wr=0.
- Reset mid-run aborts immediately. Buffer contents are don't-care; outputs take reset values.
- busy=1 from the cycle after start until the cycle done pulses (inclusive).
- LOAD: K accepted cycles, minimum.
- MERGE: ≤ K + cnt cycles per party without input stalls.
- EMIT: cnt handshakes. out_data/out_last are stable while out_valid & !out_ready.
- Minimum run latency, start to done: 1 + K + (N-1)·K + cnt + 1 cycles.
- in_valid low stalls any state without loss. start during busy has no effect.

## Configuration
- PSI_ORDER_CHECK_EN defined:
  - A prev register per party tracks the last accepted element.
  - An accepted element less than prev, excluding each party's first element, sets order_err=1.
  - order_err stays set until the next start or reset.
  - Processing continues unchanged; the result is undefined when order_err=1.
- PSI_ORDER_CHECK_EN not defined: no prev register; order_err tied to 0.

## Test plan
- W=8,K=4,N=3. Parties {1,3,5,7},{3,4,5,6},{0,3,5,9}, out_ready=1 → outputs 3 then 5 (out_last on 5), done, out_count=2.
- Disjoint {1,2,3,4},{5,6,7,8},{1,5,9,10} → no out_valid. All 12 elements accepted. done with out_count=0.
- All parties {10,20,30,40}, out_ready toggling each cycle → outputs 10,20,30,40, each held stable while stalled. out_last on 40, out_count=4.
- rst_n low during MERGE of party 1 → all outputs at reset values within the same cycle. A new start with the first scenario's stimulus gives 3,5.
- With PSI_ORDER_CHECK_EN: party 1 sends {5,3,6,7} → order_err=1 from the accept of 3, sticky until next start. Without the macro, order_err=0 throughout.
- Boundary values, W=8: parties {0,1,254,255} ×3 with N=3 → outputs 0,1,254,255. out_count=4.
